mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (I/D cache) arbiter onto a single memory port with an IDLE/MEM/DONE FSM.
// Optional MEM_ARB_ROUND_ROBIN_EN: fair grant on contention instead of fixed D priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req_i,
    input  logic                  i_wen_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [DATA_WIDTH-1:0] i_wdata_i,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_ready_o,
    input  logic                  d_req_i,
    input  logic                  d_wen_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_ready_o,
    output logic                  mem_req_o,
    output logic                  mem_wen_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i
);

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_e;

    state_e                state_q, state_d;
    logic                  own_q, own_d;  // 1 = data port
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign gnt_d = d_req_i & (~i_req_i | ~last_q);
`else
    assign gnt_d = d_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    state_d = MEM;
                    own_d   = gnt_d;
                    wen_d   = gnt_d ? d_wen_i : i_wen_i;
                    addr_d  = gnt_d ? d_addr_i : i_addr_i;
                    wdata_d = gnt_d ? d_wdata_i : i_wdata_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = gnt_d;
`endif
                end
            end
            MEM: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                    if (!wen_q) begin
                        if (own_q) d_rdata_d = mem_rdata_i;
                        else       i_rdata_d = mem_rdata_i;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign mem_req_o   = (state_q == MEM);
    assign mem_wen_o   = (state_q == MEM) & wen_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign i_ready_o   = (state_q == DONE) & ~own_q;
    assign d_ready_o   = (state_q == DONE) & own_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, writes, arbitration, reset, stray mem_ready.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_wen, d_req, d_wen;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready;
    logic        mem_req, mem_wen, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic        last_d;
    logic        exp_d;
    logic [31:0] exp_i_rd, exp_d_rd;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_wen_i(i_wen), .i_addr_i(i_addr),
        .i_wdata_i(i_wdata), .i_rdata_o(i_rdata), .i_ready_o(i_ready),
        .d_req_i(d_req), .d_wen_i(d_wen), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_ready_o(d_ready),
        .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant seen at next edge, memory answers at once, then DONE.
    task automatic serve(input logic dsel, input logic [31:0] rd);
        step();
        check("srv_req", {31'd0, mem_req}, 32'd1);
        check("srv_addr", mem_addr, dsel ? 32'h300 : 32'h200);
        mem_ready = 1'b1;
        mem_rdata = rd;
        step();
        if (dsel) exp_d_rd = rd;
        else      exp_i_rd = rd;
        check("srv_rdy", {30'd0, i_ready, d_ready}, dsel ? 32'd1 : 32'd2);
        check("srv_i_rd", i_rdata, exp_i_rd);
        check("srv_d_rd", d_rdata, exp_d_rd);
        mem_ready = 1'b0;
        last_d = dsel;
    endtask

    function automatic logic contention_grant(input logic last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return ~last;
`else
        return 1'b1 | last;
`endif
    endfunction

    initial begin
        rst_n = 1'b0;
        i_req = 0; i_wen = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        exp_i_rd = 0; exp_d_rd = 0; last_d = 1'b0;
        step();
        step();
        check("rst_out", {28'd0, mem_req, mem_wen, i_ready, d_ready}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // d read, memory ready in first MEM cycle
        d_req = 1; d_wen = 0; d_addr = 32'h40;
        step();
        check("d_memreq", {31'd0, mem_req}, 32'd1);
        check("d_addr", mem_addr, 32'h40);
        check("d_wen", {31'd0, mem_wen}, 32'd0);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("d_memreq_off", {31'd0, mem_req}, 32'd0);
        check("d_rdy", {30'd0, i_ready, d_ready}, 32'd1);
        check("d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("d_i_rdata", i_rdata, 32'd0);
        exp_d_rd = 32'hDEAD_BEEF; last_d = 1'b1;
        mem_ready = 0; d_req = 0;
        step();
        check("d_idle_rdy", {30'd0, i_ready, d_ready}, 32'd0);

        // i write with three-cycle memory wait
        i_req = 1; i_wen = 1; i_addr = 32'h100; i_wdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            step();
            check("iw_req_wen", {30'd0, mem_req, mem_wen}, 32'd3);
            check("iw_addr", mem_addr, 32'h100);
            check("iw_wdata", mem_wdata, 32'h1234_5678);
            check("iw_rdy0", {30'd0, i_ready, d_ready}, 32'd0);
            i_addr = 32'hFFFF_FFF0;
            d_req = 1; d_wen = 0; d_addr = 32'h300;
            if (k == 2) mem_ready = 1;
        end
        step();
        check("iw_rdy", {30'd0, i_ready, d_ready}, 32'd2);
        check("iw_i_rdata", i_rdata, 32'd0);
        check("iw_memreq_off", {30'd0, mem_req, mem_wen}, 32'd0);
        last_d = 1'b0;
        mem_ready = 0; i_req = 0; i_wen = 0; d_req = 0;
        step();
        check("iw_idle", {30'd0, i_ready, d_ready}, 32'd0);

        // simultaneous reads, three rounds, loser then served alone
        i_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            i_req = 1; d_req = 1;
            exp_d = contention_grant(last_d);
            serve(exp_d, 32'hA000_0000 + k);
            if (exp_d) d_req = 0;
            else       i_req = 0;
            step();
            serve(~exp_d, 32'hB000_0000 + k);
            i_req = 0; d_req = 0;
            step();
        end

        // both requests held continuously
        i_req = 1; d_req = 1;
        for (int k = 0; k < 4; k++) begin
            exp_d = contention_grant(last_d);
            serve(exp_d, 32'hC000_0000 + k);
            step();
        end
        i_req = 0; d_req = 0;
        step();

        // reset in the middle of a memory access
        i_req = 1; i_wen = 0;
        step();
        check("rst_mid_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        check("rst_mid_out", {29'd0, mem_req, i_ready, d_ready}, 32'd0);
        check("rst_mid_rd", i_rdata | d_rdata, 32'd0);
        i_req = 0;
        exp_i_rd = 0; exp_d_rd = 0; last_d = 1'b0;
        step();
        rst_n = 1;
        step();
        i_req = 1;
        serve(1'b0, 32'hCAFE_0001);
        i_req = 0;
        step();

        // stray mem_ready while idle
        mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        step();
        check("stray_rdy", {29'd0, mem_req, i_ready, d_ready}, 32'd0);
        step();
        check("stray_rdy2", {29'd0, mem_req, i_ready, d_ready}, 32'd0);
        check("stray_i_rd", i_rdata, 32'hCAFE_0001);
        check("stray_d_rd", d_rdata, 32'd0);
        mem_ready = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
